sub_fpu_seq: RTL and testbench
==============================

# sub_fpu_seq

Multi-cycle IEEE-754 single-precision subtractor computing Result = A − B; it is the inverse-direction companion to the team's combinational FP adder and shares its operand/result/NaN conventions. It is an iterative FSM with a start/done handshake: alignment and normalization shift one bit per cycle, trading latency for area. It sits beside the adder in the FPU datapath and is selected by the FPU op decoder for subtract operations.

## Interface

Parameters:
- none; widths are fixed by the single-precision format (1 sign, 8 exponent, 23 fraction bits).

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  request; sampled only in IDLE
- A  in  32  minuend, IEEE-754 single; captured on an accepted start
- B  in  32  subtrahend, IEEE-754 single; captured on an accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, high only in DONE
- Result  out  32  A − B; held stable from DONE until the next accepted start
- NaN_error  out  1  set with Result when the result is NaN; held with Result

## Operation

- Reset: state IDLE; busy=0, done=0, Result=32'h00000000, NaN_error=0. rst mid-operation aborts the operation and returns to this state on the same edge.
- IDLE: start=1 captures A and B (B sign inverted) and moves to UNPACK. start=0 stays in IDLE.
- start asserted outside IDLE is ignored and is not queued.
- UNPACK: classifies both operands.
  - Exponent 0 is treated as zero; denormals are flushed to zero.
  - Either operand NaN, or (+Inf) − (+Inf), or (−Inf) − (−Inf): Result=32'h7FC00000, NaN_error=1, go to DONE.
  - Otherwise Inf: Result is the signed Inf, go to DONE.
  - A zero: Result = B with sign flipped. B zero: Result = A. Both zero: Result = +0. Each goes to DONE.
  - Otherwise: swap so the larger exponent is first, and load 27-bit mantissas (hidden 1, 23 fraction bits, guard, round, sticky).
  - d = min(exponent difference, 26). Go to ALIGN, or directly to SUB if d=0.
- ALIGN: shifts the smaller mantissa right by 1 per cycle. Bits shifted out OR into sticky. Decrement d; go to SUB after the cycle in which d reaches 0.
- SUB: effective add or subtract of the magnitudes; the result sign follows the larger magnitude.
  - Carry-out: shift right 1, exponent +1.
  - Exact zero: Result = +0, go to DONE.
  - Otherwise go to NORM if the MSB is 0, else to ROUND.
- NORM: shift left 1 per cycle and decrement the exponent while MSB=0 and exponent > 1. Then go to ROUND.
- ROUND: round to nearest, ties to even, using guard/round/sticky. A mantissa overflow from rounding renormalizes and increments the exponent.
  - Exponent ≥ 255: signed Inf.
  - Exponent ≤ 0 after normalization: signed zero (flush).
  - Go to DONE.
- DONE: done=1 for one cycle, Result and NaN_error registered and valid, then go to IDLE.
- NaN_error is cleared on every non-NaN result.

## Timing

- Edge 0 is the rising edge that accepts start.
- done is high in cycle 4+d+n after edge 0, where n is the number of NORM shifts (0–26).
  - Special and zero-operand cases: cycle 2.
  - Exact zero difference: cycle 3+d.
- Worst case: 56 cycles (d=26, n=26).
- busy rises on the cycle after edge 0 and falls on the edge that leaves DONE.
- A new start may be asserted in the cycle done is high. It is accepted on the following edge, once the block is in IDLE. This gives a minimum of 1 idle cycle between operations.
- Result and NaN_error change only on the edge that enters DONE, or on reset.

## Structure

- Shared package fpu_pkg holds:
  - the state enum (IDLE, UNPACK, ALIGN, SUB, NORM, ROUND, DONE);
  - FP32_QNAN = 32'h7FC00000, EXP_BIAS = 127, EXP_MAX = 255, MANT_W = 27;
  - the unpacked-operand struct (sign, exp, mant, is_zero, is_inf, is_nan).
- Sub-module fpu_classify: combinational; one 32-bit operand in, the unpacked struct out. Instantiated twice in UNPACK, and reusable by the adder.
- The rest of the block is a single FSM with its datapath registers.

## Test plan

- A=32'h4019999a (2.4), B=32'h3f99999a (1.2): Result=32'h3f99999a, NaN_error=0, done in cycle 6 (d=1, n=1).
- A=32'h00000000 (0.0), B=32'h3f4ccccd (0.8): Result=32'hbf4ccccd, NaN_error=0, done in cycle 2.
- A=32'h7FC00000 (NaN), B=32'h40fb3333 (7.85): Result=32'h7FC00000, NaN_error=1; then A=B=32'h7f800000 (+Inf − +Inf): same NaN result.
- A=B=32'h3f800000 (1.0 − 1.0): Result=32'h00000000 in cycle 3. Then A=32'h3f800000, B=32'h33800000 (2^−24): Result=32'h3f7fffff, exercising d=24, NORM and sticky rounding.
- start pulsed while busy: ignored, first Result unchanged, no extra done. rst asserted mid-ALIGN: next cycle busy=0, done=0, Result=0, NaN_error=0, and a subsequent start completes correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: sequencer states, FP32 constants and the unpacked-operand record.
package fpu_pkg;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam int          EXP_BIAS  = 127;
  localparam int          EXP_MAX   = 255;
  localparam int          MANT_W    = 27;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_SUB    = 3'd3,
    ST_NORM   = 3'd4,
    ST_ROUND  = 3'd5,
    ST_DONE   = 3'd6
  } fpu_state_e;

  // mant layout: [26] hidden one, [25:3] fraction, [2] guard, [1] round, [0] sticky
  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp_unpacked_t;

endpackage

// File: rtl/fpu_classify.sv
// Combinational FP32 operand classifier; denormals are flushed to zero.
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [31:0]  op_i,
  output fp_unpacked_t unp_o
);

  // Split fields and flag zero / infinity / NaN
  always_comb begin
    unp_o.sign    = op_i[31];
    unp_o.exp     = op_i[30:23];
    unp_o.mant    = {1'b1, op_i[22:0], 3'b000};
    unp_o.is_zero = (op_i[30:23] == 8'h00);
    unp_o.is_inf  = (op_i[30:23] == 8'hFF) && (op_i[22:0] == 23'd0);
    unp_o.is_nan  = (op_i[30:23] == 8'hFF) && (op_i[22:0] != 23'd0);
  end

endmodule

// File: rtl/sub_fpu_seq.sv
// Iterative FP32 subtractor (A - B): one-bit-per-cycle alignment and normalisation.
module sub_fpu_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result,
  output logic        NaN_error
);

  fpu_state_e               state_q, state_d;
  logic [31:0]              opa_q, opa_d;
  logic [31:0]              opb_q, opb_d;
  logic                     sa_q, sa_d;
  logic                     sb_q, sb_d;
  logic signed [9:0]        ea_q, ea_d;
  logic [MANT_W-1:0]        ma_q, ma_d;
  logic [MANT_W-1:0]        mb_q, mb_d;
  logic [4:0]               d_q, d_d;
  logic [31:0]              res_q, res_d;
  logic                     nan_q, nan_d;

  fp_unpacked_t             ca, cb;
  logic [MANT_W:0]          sum_w;
  logic                     sgn_w;
  logic [7:0]               diff_w;

  // Round-to-nearest-even on guard/round/sticky, then pack with overflow/underflow handling
  function automatic logic [31:0] round_pack(input logic s,
                                             input logic signed [9:0] e,
                                             input logic [MANT_W-1:0] m);
    logic [24:0]       r;
    logic signed [9:0] en;
    logic              up;
    up = m[2] & (m[1] | m[0] | m[3]);
    r  = {1'b0, m[26:3]} + {24'd0, up};
    en = e;
    if (r[24]) begin
      r  = r >> 1;
      en = e + 10'sd1;
    end
    if (en >= 10'sd255)
      round_pack = {s, 8'hFF, 23'd0};
    else if ((en <= 10'sd0) || !r[23])
      round_pack = {s, 31'd0};
    else
      round_pack = {s, en[7:0], r[22:0]};
  endfunction

  fpu_classify u_cls_a (.op_i(opa_q), .unp_o(ca));
  fpu_classify u_cls_b (.op_i(opb_q), .unp_o(cb));

  // Next-state and datapath update for each sequencer state
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ea_d    = ea_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    d_d     = d_q;
    res_d   = res_q;
    nan_d   = nan_q;
    sum_w   = '0;
    sgn_w   = 1'b0;
    diff_w  = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opa_d   = A;
          opb_d   = {~B[31], B[30:0]};
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        state_d = ST_DONE;
        nan_d   = 1'b0;
        if (ca.is_nan || cb.is_nan || (ca.is_inf && cb.is_inf && (ca.sign != cb.sign))) begin
          res_d = FP32_QNAN;
          nan_d = 1'b1;
        end else if (ca.is_inf) begin
          res_d = opa_q;
        end else if (cb.is_inf) begin
          res_d = opb_q;
        end else if (ca.is_zero && cb.is_zero) begin
          res_d = 32'h0000_0000;
        end else if (ca.is_zero) begin
          res_d = opb_q;
        end else if (cb.is_zero) begin
          res_d = opa_q;
        end else begin
          // Larger exponent goes in the A slot; B slot is the one aligned
          if (cb.exp > ca.exp) begin
            sa_d   = cb.sign;
            ea_d   = signed'({2'b00, cb.exp});
            ma_d   = cb.mant;
            sb_d   = ca.sign;
            mb_d   = ca.mant;
            diff_w = cb.exp - ca.exp;
          end else begin
            sa_d   = ca.sign;
            ea_d   = signed'({2'b00, ca.exp});
            ma_d   = ca.mant;
            sb_d   = cb.sign;
            mb_d   = cb.mant;
            diff_w = ca.exp - cb.exp;
          end
          d_d     = (diff_w > 8'd26) ? 5'd26 : diff_w[4:0];
          state_d = (diff_w == 8'd0) ? ST_SUB : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        mb_d = {1'b0, mb_q[MANT_W-1:2], mb_q[1] | mb_q[0]};
        d_d  = d_q - 5'd1;
        if (d_q == 5'd1) state_d = ST_SUB;
      end
      ST_SUB: begin
        if (sa_q == sb_q) begin
          sum_w = {1'b0, ma_q} + {1'b0, mb_q};
          sgn_w = sa_q;
        end else if (ma_q >= mb_q) begin
          sum_w = {1'b0, ma_q} - {1'b0, mb_q};
          sgn_w = sa_q;
        end else begin
          sum_w = {1'b0, mb_q} - {1'b0, ma_q};
          sgn_w = sb_q;
        end
        sa_d = sgn_w;
        if (sum_w[MANT_W]) begin
          ma_d    = {sum_w[MANT_W:2], sum_w[1] | sum_w[0]};
          ea_d    = ea_q + 10'sd1;
          state_d = ST_ROUND;
        end else if (sum_w[MANT_W-1:0] == '0) begin
          res_d   = 32'h0000_0000;
          nan_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          ma_d    = sum_w[MANT_W-1:0];
          state_d = (!sum_w[MANT_W-1] && (ea_q > 10'sd1)) ? ST_NORM : ST_ROUND;
        end
      end
      ST_NORM: begin
        // Entered only when a shift is due; leave once the MSB lands or exponent bottoms out
        ma_d = {ma_q[MANT_W-2:0], 1'b0};
        ea_d = ea_q - 10'sd1;
        if (ma_q[MANT_W-2] || (ea_q <= 10'sd2)) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        res_d   = round_pack(sa_q, ea_q, ma_q);
        nan_d   = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and visible result registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= 32'h0000_0000;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      nan_q   <= nan_d;
    end
  end

  // Working datapath registers; only meaningful while busy, so left unreset
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
    sa_q  <= sa_d;
    sb_q  <= sb_d;
    ea_q  <= ea_d;
    ma_q  <= ma_d;
    mb_q  <= mb_d;
    d_q   <= d_d;
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign Result    = res_q;
  assign NaN_error = nan_q;

endmodule

// File: tb/tb_sub_fpu_seq.sv
// Directed scoreboard bench for the sequential FP32 subtractor.
module tb_sub_fpu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] Result;
  logic        NaN_error;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_res[$];
  logic        exp_nan[$];
  int          exp_lat[$];

  sub_fpu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Result    (Result),
    .NaN_error (NaN_error)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at the negedge of cycle cyc_in; returns the cycle in which done was seen
  task automatic wait_done(input string tag, input int cyc_in, output int cyc);
    cyc = cyc_in;
    while (done !== 1'b1 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic pop_check(input string tag, input int cyc);
    logic [31:0] r;
    logic        n;
    int          l;
    r = exp_res.pop_front();
    n = exp_nan.pop_front();
    l = exp_lat.pop_front();
    chk({tag, " Result"}, Result, r);
    chk({tag, " NaN_error"}, {31'd0, NaN_error}, {31'd0, n});
    chk({tag, " latency"}, cyc, l);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic en, input int el);
    int cyc;
    exp_res.push_back(er);
    exp_nan.push_back(en);
    exp_lat.push_back(el);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom;
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    wait_done(tag, 1, cyc);
    pop_check(tag, cyc);
  endtask

  initial begin
    int cyc;
    int extra;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset Result", Result, 32'h0000_0000);
    chk("reset NaN_error", {31'd0, NaN_error}, 32'd0);

    do_op("2.4-1.2",     32'h4019999a, 32'h3f99999a, 32'h3f99999a, 1'b0, 6);
    do_op("0-0.8",       32'h00000000, 32'h3f4ccccd, 32'hbf4ccccd, 1'b0, 2);
    do_op("NaN-7.85",    32'h7FC00000, 32'h40fb3333, 32'h7FC00000, 1'b1, 2);
    do_op("Inf-Inf",     32'h7f800000, 32'h7f800000, 32'h7FC00000, 1'b1, 2);

    // Abort mid-ALIGN: operation with d=24, reset during cycle 3
    @(negedge clk);
    A = 32'h3f800000; B = 32'h33800000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort Result", Result, 32'h0000_0000);
    chk("abort NaN_error", {31'd0, NaN_error}, 32'd0);
    do_op("post-abort",  32'h4019999a, 32'h3f99999a, 32'h3f99999a, 1'b0, 6);

    do_op("1-1",         32'h3f800000, 32'h3f800000, 32'h00000000, 1'b0, 3);
    do_op("1-2^-24",     32'h3f800000, 32'h33800000, 32'h3f7fffff, 1'b0, 29);
    do_op("1+2^-24 tie", 32'h3f800000, 32'hb3800000, 32'h3f800000, 1'b0, 28);
    do_op("1+1 carry",   32'h3f800000, 32'hbf800000, 32'h40000000, 1'b0, 4);
    do_op("max ovf",     32'h7f7fffff, 32'hff7fffff, 32'h7f800000, 1'b0, 4);
    do_op("Inf-1",       32'h7f800000, 32'h3f800000, 32'h7f800000, 1'b0, 2);
    do_op("pi-0",        32'h40490fdb, 32'h80000000, 32'h40490fdb, 1'b0, 2);

    // Start pulsed while busy must be ignored
    exp_res.push_back(32'h3f99999a);
    exp_nan.push_back(1'b0);
    exp_lat.push_back(6);
    @(negedge clk);
    A = 32'h4019999a; B = 32'h3f99999a; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); A = 32'h3f800000; B = 32'hbf800000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("busy-start", 3, cyc);
    pop_check("busy-start", cyc);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk("busy-start extra done", extra, 0);
    chk("busy-start held Result", Result, 32'h3f99999a);
    chk("busy-start idle", {31'd0, busy}, 32'd0);

    chk("scoreboard empty", exp_res.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
